// File: rtl/phase_to_amplitude_if.sv
// Sample bus between the DDS phase accumulator and the PWM modulator.
// The master drives phase samples and the slave returns amplitude samples.
interface phase_to_amplitude_if #(
    parameter int PHASE_W = 24,
    parameter int AMP_W   = 10
);
    logic                      en;
    logic [PHASE_W-1:0]        phase_in;
    logic [PHASE_W-1:0]        phase_offset;
    logic signed [AMP_W-1:0]   amp_out;
    logic [AMP_W-1:0]          duty_out;
    logic                      valid_out;

    modport master (
        output en, phase_in, phase_offset,
        input  amp_out, duty_out, valid_out
    );

    modport slave (
        input  en, phase_in, phase_offset,
        output amp_out, duty_out, valid_out
    );
endinterface

// File: rtl/phase_to_amplitude.sv
// Three-stage phase-to-amplitude converter: offset add and truncate, quarter-wave
// ROM lookup with quadrant folding, then sign restore with an offset-binary duty word.
module phase_to_amplitude #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    phase_to_amplitude_if.slave  bus
);
    localparam int ROM_N = 1 << LUT_AW;
    localparam int ROM_W = AMP_W - 1;
    localparam int SHIFT = PHASE_W - LUT_AW - 2;

    // Half-LSB phase offset keeps quadrant edges free of duplicate samples.
    function automatic int rom_entry(input int k);
        real ang;
        real v;
        ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(ROM_N);
        v   = real'((1 << (AMP_W - 1)) - 1) * $sin(ang);
        return $rtoi(v + 0.5);
    endfunction

    logic [ROM_W-1:0] w_rom [ROM_N];

    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        localparam int RomVal = rom_entry(k);
        assign w_rom[k] = ROM_W'(RomVal);
    end

    logic [LUT_AW+1:0]       w_phase_hi;
    logic [LUT_AW-1:0]       w_rom_addr;
    logic [AMP_W-1:0]        w_mag;
    logic [AMP_W-1:0]        w_amp_nxt;

    logic [2:0]              r_vld;
    logic [1:0]              r_quad;
    logic [LUT_AW-1:0]       r_addr;
    logic [ROM_W-1:0]        r_rom;
    logic                    r_neg;
    logic [AMP_W-1:0]        r_amp;

    // Sum is taken at full phase width so the carry out is dropped before truncation.
    assign w_phase_hi = (LUT_AW + 2)'((bus.phase_in + bus.phase_offset) >> SHIFT);
    assign w_rom_addr = r_quad[0] ? ~r_addr : r_addr;
    assign w_mag      = {1'b0, r_rom};
    assign w_amp_nxt  = r_neg ? -w_mag : w_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_quad <= '0;
            r_addr <= '0;
            r_rom  <= '0;
            r_neg  <= 1'b0;
            r_amp  <= '0;
        end else begin
            r_vld <= {r_vld[1:0], bus.en};
            if (bus.en) begin
                r_quad <= w_phase_hi[LUT_AW+1:LUT_AW];
                r_addr <= w_phase_hi[LUT_AW-1:0];
            end
            if (r_vld[0]) begin
                r_rom <= w_rom[w_rom_addr];
                r_neg <= r_quad[1];
            end
            if (r_vld[1]) begin
                r_amp <= w_amp_nxt;
            end
        end
    end

    assign bus.amp_out   = r_amp;
    assign bus.duty_out  = {~r_amp[AMP_W-1], r_amp[AMP_W-2:0]};
    assign bus.valid_out = r_vld[2];
endmodule

// File: tb/tb_phase_to_amplitude.sv
// Randomized self-checking bench for phase_to_amplitude against a direct sine model.
module tb_phase_to_amplitude;
    logic clk = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hold = 0;
    int due_q[$];
    int amp_q[$];

    phase_to_amplitude_if #(.PHASE_W(24), .AMP_W(10)) bus ();

    phase_to_amplitude #(.PHASE_W(24), .LUT_AW(8), .AMP_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Amplitude sampled at the centre of the 10-bit phase bin.
    function automatic int ref_amp(input logic [23:0] p);
        int  idx;
        real s;
        int  m;
        idx = int'(p >> 14);
        s   = $sin(2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 1024.0);
        m   = $rtoi(511.0 * ((s < 0.0) ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    task automatic step(input logic e, input logic [23:0] ph, input logic [23:0] off);
        logic [23:0] sum;
        bus.en = e;
        bus.phase_in = ph;
        bus.phase_offset = off;
        sum = ph + off;
        @(posedge clk);
        cyc++;
        if (e && !reset) begin
            due_q.push_back(cyc + 2);
            amp_q.push_back(ref_amp(sum));
        end
        #1;
    endtask

    task automatic expect_now(output bit v, output int a);
        v = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            v = 1'b1;
            hold = amp_q.pop_front();
            void'(due_q.pop_front());
        end
        a = hold;
    endtask

    task automatic flush_model();
        due_q.delete();
        amp_q.delete();
        hold = 0;
    endtask

    task automatic test_reset();
        bit v;
        int a;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), 24'($urandom), 24'($urandom));
            total += 3;
            if (bus.valid_out !== 1'b0) begin
                bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_out);
            end
            if (bus.amp_out !== 10'sd0) begin
                bad++; $display("FAIL reset_amp got=%0d want=0", bus.amp_out);
            end
            if (bus.duty_out !== 10'd512) begin
                bad++; $display("FAIL reset_duty got=%0d want=512", bus.duty_out);
            end
        end
        reset = 1'b0;
        flush_model();
        step(1'b1, 24'h0, 24'h0);
        step(1'b0, 24'h0, 24'h0);
        step(1'b0, 24'h0, 24'h0);
        expect_now(v, a);
        total += 3;
        if (bus.valid_out !== 1'b1) begin
            bad++; $display("FAIL first_valid got=%b want=1", bus.valid_out);
        end
        if (int'(bus.amp_out) != 2) begin
            bad++; $display("FAIL first_amp got=%0d want=2", bus.amp_out);
        end
        if (bus.duty_out !== 10'd514) begin
            bad++; $display("FAIL first_duty got=%0d want=514", bus.duty_out);
        end
    endtask

    task automatic test_quadrants();
        logic [23:0] ph [7] = '{24'h000000, 24'h3FFFFF, 24'h400000, 24'h800000,
                                24'hC00000, 24'h000000, 24'hC00000};
        logic [23:0] of [7] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h400000, 24'h800000};
        int          ex [7] = '{2, 511, 511, -2, -511, 511, 511};
        bit v;
        int a;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, ph[i], of[i]);
            step(1'b0, 24'h0, 24'h0);
            step(1'b0, 24'h0, 24'h0);
            expect_now(v, a);
            total += 4;
            if (bus.valid_out !== 1'b1) begin
                bad++; $display("FAIL quad%0d_valid got=%b want=1", i, bus.valid_out);
            end
            if (int'(bus.amp_out) != ex[i]) begin
                bad++; $display("FAIL quad%0d_amp got=%0d want=%0d", i, bus.amp_out, ex[i]);
            end
            if (int'(bus.amp_out) != a) begin
                bad++; $display("FAIL quad%0d_model got=%0d want=%0d", i, bus.amp_out, a);
            end
            if (bus.duty_out !== 10'(ex[i] + 512)) begin
                bad++; $display("FAIL quad%0d_duty got=%0d want=%0d", i, bus.duty_out,
                                ex[i] + 512);
            end
        end
    endtask

    task automatic test_stream();
        logic [23:0] acc = 24'h0;
        logic [23:0] off = 24'($urandom);
        int obs[$];
        bit v;
        int a;
        for (int t = 0; t < 259; t++) begin
            step(t < 256, acc, off);
            acc = acc + 24'h010000;
            expect_now(v, a);
            total += 2;
            if (bus.valid_out !== v) begin
                bad++; $display("FAIL stream_valid t=%0d got=%b want=%b", t, bus.valid_out, v);
            end
            if (int'(bus.amp_out) != a || bus.duty_out !== 10'(a + 512)) begin
                bad++; $display("FAIL stream_amp t=%0d got=%0d/%0d want=%0d/%0d", t,
                                bus.amp_out, bus.duty_out, a, a + 512);
            end
            if (bus.valid_out === 1'b1) obs.push_back(int'(bus.amp_out));
        end
        total++;
        if (obs.size() != 256) begin
            bad++; $display("FAIL stream_count got=%0d want=256", obs.size());
        end else begin
            for (int i = 0; i < 128; i++) begin
                total++;
                if (obs[i] != -obs[i+128]) begin
                    bad++; $display("FAIL stream_sym i=%0d got=%0d want=%0d", i, obs[i+128],
                                    -obs[i]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        bit en_pat [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0};
        bit v;
        int a;
        for (int t = 0; t < 10; t++) begin
            step(en_pat[t], 24'($urandom), 24'($urandom));
            expect_now(v, a);
            total += 2;
            if (bus.valid_out !== v) begin
                bad++; $display("FAIL bubble_valid t=%0d got=%b want=%b", t, bus.valid_out, v);
            end
            if (int'(bus.amp_out) != a || bus.duty_out !== 10'(a + 512)) begin
                bad++; $display("FAIL bubble_hold t=%0d got=%0d want=%0d", t, bus.amp_out, a);
            end
        end
    endtask

    task automatic test_random();
        bit v;
        int a;
        for (int t = 0; t < 300; t++) begin
            step(($urandom % 4) != 0 || t >= 297 ? (t < 297) : 1'b0,
                 24'($urandom), 24'($urandom));
            expect_now(v, a);
            total += 2;
            if (bus.valid_out !== v) begin
                bad++; $display("FAIL rand_valid t=%0d got=%b want=%b", t, bus.valid_out, v);
            end
            if (int'(bus.amp_out) != a || bus.duty_out !== 10'(a + 512)) begin
                bad++; $display("FAIL rand_amp t=%0d got=%0d want=%0d", t, bus.amp_out, a);
            end
        end
    endtask

    task automatic test_midreset();
        bit v;
        int a;
        step(1'b1, 24'h400000, 24'h0);
        step(1'b1, 24'h400000, 24'h0);
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (bus.valid_out !== 1'b0 || bus.amp_out !== 10'sd0) begin
            bad++; $display("FAIL midrst_async got=%b/%0d want=0/0", bus.valid_out, bus.amp_out);
        end
        if (bus.duty_out !== 10'd512) begin
            bad++; $display("FAIL midrst_duty got=%0d want=512", bus.duty_out);
        end
        flush_model();
        step(1'b0, 24'h0, 24'h0);
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step(1'b0, 24'h0, 24'h0);
            expect_now(v, a);
            total += 2;
            if (bus.valid_out !== v) begin
                bad++; $display("FAIL midrst_valid t=%0d got=%b want=%b", t, bus.valid_out, v);
            end
            if (int'(bus.amp_out) != a || bus.duty_out !== 10'(a + 512)) begin
                bad++; $display("FAIL midrst_amp t=%0d got=%0d want=%0d", t, bus.amp_out, a);
            end
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.phase_in = '0;
        bus.phase_offset = '0;
        test_reset();
        test_quadrants();
        test_stream();
        test_bubbles();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/phase_to_amplitude.md
Name: phase_to_amplitude

Overview:
- Pipelined phase-to-amplitude converter. Sits directly downstream of the DDS phase accumulator and upstream of the PWM modulator.
- Adds a programmable phase offset and truncates the phase to LUT_AW+2 bits.
- Maps the truncated phase through a quarter-wave sine ROM using quadrant symmetry.
- Delivers a signed sample and an offset-binary duty word, with a valid strobe.

Parameters:
- PHASE_W, 24, accumulator phase width.
- LUT_AW, 8, quarter-wave ROM address width (2^LUT_AW entries).
- AMP_W, 10, output amplitude width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  input-sample valid; phase_in/phase_offset sampled when high.
- phase_in  input  PHASE_W  accumulator phase, unsigned, wraps at 2^PHASE_W.
- phase_offset  input  PHASE_W  phase offset, unsigned, added modulo 2^PHASE_W.
- amp_out  output  AMP_W  signed two's-complement sine sample.
- duty_out  output  AMP_W  unsigned duty word = amp_out + 2^(AMP_W-1) (amp_out with MSB inverted).
- valid_out  output  1  high for one cycle per accepted en, 3 cycles later.

Behaviour:
- Reset values (async, immediate): all pipeline registers 0; valid pipe 0; amp_out 0; duty_out 2^(AMP_W-1) (512 at default); valid_out 0.
- ROM contents, fixed at elaboration: entry k = round((2^(AMP_W-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW)), k = 0..2^LUT_AW-1. Defaults: entry 0 = 2, entry 255 = 511. Half-LSB offset means no duplicate values at quadrant boundaries.
- Stage 1 (on en):
  - p = (phase_in + phase_offset) mod 2^PHASE_W.
  - Register quad = p[PHASE_W-1:PHASE_W-2].
  - Register addr = p[PHASE_W-3:PHASE_W-2-LUT_AW]; lower bits discarded (truncation, no rounding).
- Stage 2:
  - ROM address = addr for quad 0 and 2; ~addr for quad 1 and 3.
  - Register ROM output (unsigned, AMP_W-1 bits) and the negate flag = quad[1].
- Stage 3:
  - amp_out = negate ? -rom : +rom, sign-extended to AMP_W.
  - duty_out = amp_out with MSB inverted.
  - Range is ±(2^(AMP_W-1)-1). Most-negative code never produced, so duty_out is never 0.
- Latency: exactly 3 clk from an en-high edge to the valid_out-high cycle.
- Throughput: one sample per clock; the pipeline never stalls.
- valid pipe is a 3-bit shift of en.
- Each data stage loads only when its stage-valid is high. During bubbles (en low) amp_out/duty_out hold their last value and valid_out is 0.
- Back-to-back en: one output per cycle, in order, no loss.
- Wrap-around: offset addition carry out of PHASE_W is discarded.
- Reset mid-operation: all in-flight samples are discarded. After reset deasserts, the first valid_out is 3 cycles after the first en.
- phase_offset is sampled together with phase_in; a change takes effect on the next en sample only.

Test Plan:
- Reset: assert reset with en toggling -> amp_out=0, duty_out=512, valid_out=0. Deassert, en=1 at phase_in=0, offset=0 -> valid_out high 3 cycles later with amp_out=2, duty_out=514.
- Quadrant points, offset 0:
  - phase_in 0x000000 -> 2 / 514.
  - phase_in 0x3FFFFF -> 511 / 1023.
  - phase_in 0x400000 -> 511 / 1023.
  - phase_in 0x800000 -> -2 / 510.
  - phase_in 0xC00000 -> -511 / 1.
- Offset and wrap:
  - phase_in 0, offset 0x400000 -> 511.
  - phase_in 0xC00000, offset 0x800000 (sum wraps to 0x400000) -> 511.
- Streaming: drive a real accumulator sequence with FCW=0x010000, en held high -> valid_out continuously high after 3 cycles. Each output matches a reference model within 0 LSB. Output is symmetric: amp(p) = -amp(p+0x800000).
- Bubbles: en pattern 1,0,0,1 -> valid_out pattern 1,0,0,1 delayed 3 cycles; amp_out holds through the gaps.
- Mid-stream reset: en high for 2 cycles, then reset pulse -> no valid_out produced for the pre-reset samples; outputs return to 0/512.
